// File: rtl/hps_ext_pkg.sv
// Shared constants, bus bit positions and command decode for the HPS extension mailbox.
package hps_ext_pkg;

  localparam int EXT_W        = 36;
  localparam int BUS_DOUT_LSB = 0;
  localparam int BUS_DIN_LSB  = 16;
  localparam int BUS_DOUT_EN  = 32;
  localparam int BUS_STROBE   = 33;
  localparam int BUS_ENABLE   = 34;

  localparam logic [15:0] CMD_BASE_DEF = 16'h0034;

  localparam int ST_PEND    = 15;
  localparam int ST_OVF     = 14;
  localparam int ST_SEQ_LSB = 0;

  localparam int IDX_W = 10;

  typedef logic [15:0] word_t;

  typedef enum logic {
    DIR_GET = 1'b0,
    DIR_SET = 1'b1
  } dir_e;

  typedef struct packed {
    logic       hit;
    logic [2:0] ch;
    dir_e       dir;
  } cmd_dec_t;

  // Direction is taken from the offset so an odd CMD_BASE still pairs GET/SET correctly.
  function automatic cmd_dec_t cmd_decode(input logic [15:0] cmd, input logic [15:0] base,
                                          input int nch);
    cmd_dec_t    d;
    logic [15:0] off;
    off   = cmd - base;
    d.hit = (cmd >= base) && (off < 16'(2 * nch));
    d.ch  = off[3:1];
    d.dir = dir_e'(off[0]);
    return d;
  endfunction

endpackage

// File: rtl/hps_ext_mbox_if.sv
// HPS extension bus as seen by the mailbox: host drives din/strobe/enable, mailbox drives dout/dout_en.
interface hps_ext_mbox_if;
  logic [15:0] io_dout;
  logic        dout_en;
  logic [15:0] io_din;
  logic        io_strobe;
  logic        io_enable;

  modport master (output io_din, io_strobe, io_enable, input io_dout, dout_en);
  modport slave  (input io_din, io_strobe, io_enable, output io_dout, dout_en);
endinterface

// File: rtl/hps_ext_mbox_chan.sv
// One mailbox channel: core->HPS buffer with stage for captures during a GET, HPS->core shadow,
// and pending/overflow/seq status. All updates land on the clock edge after their trigger.
module hps_ext_mbox_chan
  import hps_ext_pkg::*;
#(
  parameter int WORDS = 6
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic [WORDS*16-1:0] in_data_i,
  input  logic               in_stb_i,
  input  logic               get_frame_i,
  input  logic               get_end_i,
  input  logic               get_full_i,
  input  logic               set_wr_i,
  input  logic [5:0]         set_widx_i,
  input  logic [15:0]        set_wdat_i,
  input  logic               set_done_i,
  output logic [WORDS*16-1:0] buf_o,
  output logic [WORDS*16-1:0] out_data_o,
  output logic               out_stb_o,
  output logic               pending_o,
  output logic               overflow_o,
  output logic [7:0]         seq_o
);

  word_t [WORDS-1:0] buf_q, buf_d, stage_q, stage_d, shadow_q, shadow_d, odat_q, odat_d;
  logic              stg_vld_q, stg_vld_d, stg_ovf_q, stg_ovf_d;
  logic              pend_q, pend_d, ovf_q, ovf_d, ostb_q, ostb_d;
  logic [7:0]        seq_q, seq_d;

  always_comb begin
    buf_d     = buf_q;
    stage_d   = stage_q;
    stg_vld_d = stg_vld_q;
    stg_ovf_d = stg_ovf_q;
    pend_d    = pend_q;
    ovf_d     = ovf_q;
    seq_d     = seq_q;
    shadow_d  = shadow_q;
    odat_d    = odat_q;
    ostb_d    = 1'b0;

    // Frame end: the read's clear goes first, then any staged message is published.
    if (get_end_i) begin
      if (get_full_i) begin
        pend_d = 1'b0;
        ovf_d  = 1'b0;
      end
      if (stg_vld_q) begin
        buf_d     = stage_q;
        ovf_d     = ovf_d | stg_ovf_q | pend_d;
        pend_d    = 1'b1;
        seq_d     = seq_d + 8'd1;
        stg_vld_d = 1'b0;
        stg_ovf_d = 1'b0;
      end
    end

    if (in_stb_i) begin
      if (get_frame_i && !get_end_i) begin
        stage_d   = in_data_i;
        stg_ovf_d = stg_ovf_q | stg_vld_q;
        stg_vld_d = 1'b1;
      end else begin
        buf_d  = in_data_i;
        ovf_d  = ovf_d | pend_d;
        pend_d = 1'b1;
        seq_d  = seq_d + 8'd1;
      end
    end

    for (int w = 0; w < WORDS; w++) begin
      if (set_wr_i && set_widx_i == 6'(w)) shadow_d[w] = set_wdat_i;
    end

    if (set_done_i) begin
      odat_d = shadow_q;
      ostb_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      buf_q     <= '0;
      stage_q   <= '0;
      stg_vld_q <= 1'b0;
      stg_ovf_q <= 1'b0;
      pend_q    <= 1'b0;
      ovf_q     <= 1'b0;
      seq_q     <= '0;
      shadow_q  <= '0;
      odat_q    <= '0;
      ostb_q    <= 1'b0;
    end else begin
      buf_q     <= buf_d;
      stage_q   <= stage_d;
      stg_vld_q <= stg_vld_d;
      stg_ovf_q <= stg_ovf_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      seq_q     <= seq_d;
      shadow_q  <= shadow_d;
      odat_q    <= odat_d;
      ostb_q    <= ostb_d;
    end
  end

  assign buf_o      = buf_q;
  assign out_data_o = odat_q;
  assign out_stb_o  = ostb_q;
  assign pending_o  = pend_q;
  assign overflow_o = ovf_q;
  assign seq_o      = seq_q;

endmodule

// File: rtl/hps_ext_mbox.sv
// Multi-channel HPS mailbox: decodes frames on the extension bus, muxes GET responses and
// routes SET words; io_dout/dout_en are registered one cycle after each strobe.
module hps_ext_mbox
  import hps_ext_pkg::*;
#(
  parameter int          NCH      = 2,
  parameter int          WORDS    = 6,
  parameter logic [15:0] CMD_BASE = CMD_BASE_DEF
) (
  input  logic                    clk_sys,
  input  logic                    rst_n,
  hps_ext_mbox_if.slave           EXT_BUS,
  input  logic [NCH*WORDS*16-1:0] in_data,
  input  logic [NCH-1:0]          in_stb,
  output logic [NCH*WORDS*16-1:0] out_data,
  output logic [NCH-1:0]          out_stb,
  output logic [NCH-1:0]          pending
);

  localparam logic [IDX_W-1:0] IDX_MAX   = '1;
  localparam logic [IDX_W-1:0] WORDS_IDX = IDX_W'(WORDS);
  localparam logic [IDX_W-1:0] FULL_IDX  = IDX_W'(WORDS + 1);

  logic             en_q, cmd_vld_q, dout_en_q;
  logic [IDX_W-1:0] idx_q;
  logic [15:0]      cmd_q, dout_q;

  cmd_dec_t new_dec, cur_dec;
  logic     stb, fall, full, data_idx, act;
  word_t    status, rd_word;

  logic [WORDS*16-1:0] chan_buf [NCH];
  logic [7:0]          chan_seq [NCH];
  logic [NCH-1:0]      overflow;

  assign new_dec  = cmd_decode(EXT_BUS.io_din, CMD_BASE, NCH);
  assign cur_dec  = cmd_decode(cmd_q, CMD_BASE, NCH);
  assign act      = cmd_vld_q & cur_dec.hit;
  assign stb      = EXT_BUS.io_enable & EXT_BUS.io_strobe;
  assign fall     = en_q & ~EXT_BUS.io_enable;
  assign full     = idx_q >= FULL_IDX;
  assign data_idx = (idx_q != '0) && (idx_q <= WORDS_IDX);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic sel, is_get;
    assign sel    = act && (cur_dec.ch == 3'(c));
    assign is_get = sel && (cur_dec.dir == DIR_GET);

    hps_ext_mbox_chan #(.WORDS(WORDS)) u_chan (
      .clk_sys    (clk_sys),
      .rst_n      (rst_n),
      .in_data_i  (in_data[c*WORDS*16 +: WORDS*16]),
      .in_stb_i   (in_stb[c]),
      .get_frame_i(is_get),
      .get_end_i  (is_get && fall),
      .get_full_i (full),
      .set_wr_i   (sel && (cur_dec.dir == DIR_SET) && stb && data_idx),
      .set_widx_i (6'(idx_q - 10'd1)),
      .set_wdat_i (EXT_BUS.io_din),
      .set_done_i (sel && (cur_dec.dir == DIR_SET) && fall && full),
      .buf_o      (chan_buf[c]),
      .out_data_o (out_data[c*WORDS*16 +: WORDS*16]),
      .out_stb_o  (out_stb[c]),
      .pending_o  (pending[c]),
      .overflow_o (overflow[c]),
      .seq_o      (chan_seq[c])
    );
  end

  // Status uses the command arriving now; data words use the command latched at idx 0.
  always_comb begin
    status  = '0;
    rd_word = '0;
    for (int c = 0; c < NCH; c++) begin
      if (new_dec.ch == 3'(c)) begin
        status[ST_PEND]              = pending[c];
        status[ST_OVF]               = overflow[c];
        status[ST_SEQ_LSB +: 8]      = chan_seq[c];
      end
      if (cur_dec.ch == 3'(c)) begin
        for (int w = 0; w < WORDS; w++) begin
          if (idx_q == IDX_W'(w + 1)) rd_word = chan_buf[c][w*16 +: 16];
        end
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      en_q      <= 1'b0;
      idx_q     <= '0;
      cmd_q     <= '0;
      cmd_vld_q <= 1'b0;
      dout_q    <= '0;
      dout_en_q <= 1'b0;
    end else begin
      en_q <= EXT_BUS.io_enable;
      if (!EXT_BUS.io_enable) begin
        idx_q     <= '0;
        cmd_vld_q <= 1'b0;
        dout_q    <= '0;
        dout_en_q <= 1'b0;
      end else if (EXT_BUS.io_strobe) begin
        if (idx_q != IDX_MAX) idx_q <= idx_q + 10'd1;
        dout_q <= '0;
        if (idx_q == '0) begin
          cmd_q     <= EXT_BUS.io_din;
          cmd_vld_q <= 1'b1;
          dout_en_q <= new_dec.hit;
          if (new_dec.hit && new_dec.dir == DIR_GET) dout_q <= status;
        end else if (act && cur_dec.dir == DIR_GET && data_idx) begin
          dout_q <= rd_word;
        end
      end
    end
  end

  assign EXT_BUS.io_dout = dout_q;
  assign EXT_BUS.dout_en = dout_en_q;

endmodule

// File: tb/tb_hps_ext_mbox.sv
// Directed scoreboard bench for hps_ext_mbox (NCH=2, WORDS=6, CMD_BASE='h34).
module tb_hps_ext_mbox;

  localparam int NCH = 2;
  localparam int WORDS = 6;
  localparam int DW = WORDS * 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NCH*DW-1:0] in_data = '0;
  logic [NCH-1:0]    in_stb = '0;
  logic [NCH*DW-1:0] out_data;
  logic [NCH-1:0]    out_stb;
  logic [NCH-1:0]    pending;

  hps_ext_mbox_if bus ();

  hps_ext_mbox #(.NCH(NCH), .WORDS(WORDS), .CMD_BASE(16'h0034)) dut (
    .clk_sys (clk),
    .rst_n   (rst_n),
    .EXT_BUS (bus),
    .in_data (in_data),
    .in_stb  (in_stb),
    .out_data(out_data),
    .out_stb (out_stb),
    .pending (pending)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int          ch;
    logic [DW-1:0] dat;
  } oev_t;

  logic [16:0] rq[$];
  oev_t        oq[$];

  logic [15:0] fw[16];
  logic [16:0] fe[16];
  int          inj_ch;
  logic [DW-1:0] inj_dat;

  // Response monitor: one bus response per strobe, one event per out_stb cycle.
  logic strb_seen = 1'b0;
  always @(posedge clk) strb_seen <= bus.io_enable & bus.io_strobe;

  always @(negedge clk) begin
    logic [16:0] e;
    oev_t        o;
    if (strb_seen) begin
      compared++;
      if (rq.size() == 0) begin
        mismatched++;
        $display("FAIL resp: unexpected response en=%0b dout=%h", bus.dout_en, bus.io_dout);
      end else begin
        e = rq.pop_front();
        if ({bus.dout_en, bus.io_dout} !== e) begin
          mismatched++;
          $display("FAIL resp: got en=%0b dout=%h want en=%0b dout=%h",
                   bus.dout_en, bus.io_dout, e[16], e[15:0]);
        end
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (out_stb[c]) begin
        compared++;
        if (oq.size() == 0) begin
          mismatched++;
          $display("FAIL out_stb: unexpected pulse ch%0d data=%h", c, out_data[c*DW +: DW]);
        end else begin
          o = oq.pop_front();
          if (o.ch != c || out_data[c*DW +: DW] !== o.dat) begin
            mismatched++;
            $display("FAIL out_stb: got ch%0d data=%h want ch%0d data=%h",
                     c, out_data[c*DW +: DW], o.ch, o.dat);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_in(input int ch, input logic [DW-1:0] d);
    @(negedge clk);
    in_data[ch*DW +: DW] = d;
    in_stb[ch] = 1'b1;
    @(negedge clk);
    in_stb = '0;
  endtask

  task automatic send_word(input logic [15:0] w, input logic [16:0] e);
    @(negedge clk);
    bus.io_din = w;
    bus.io_strobe = 1'b1;
    rq.push_back(e);
    @(negedge clk);
    bus.io_strobe = 1'b0;
  endtask

  // Run a frame of n words from fw/fe; optional in_stb on inj_ch after word inj_at.
  task automatic frame(input int n, input int inj_at);
    @(negedge clk);
    bus.io_enable = 1'b1;
    for (int i = 0; i < n; i++) begin
      send_word(fw[i], fe[i]);
      if (i == inj_at) begin
        in_data[inj_ch*DW +: DW] = inj_dat;
        in_stb[inj_ch] = 1'b1;
        @(negedge clk);
        in_stb = '0;
      end
    end
    @(negedge clk);
    bus.io_enable = 1'b0;
    idle(3);
  endtask

  task automatic load_get(input logic [15:0] cmd, input logic [15:0] st, input logic [DW-1:0] d,
                          input int n);
    fw[0] = cmd;
    fe[0] = {1'b1, st};
    for (int i = 1; i < n; i++) begin
      fw[i] = 16'h0;
      fe[i] = {1'b1, (i <= WORDS) ? d[(i-1)*16 +: 16] : 16'h0};
    end
  endtask

  task automatic load_set(input logic [15:0] cmd, input logic hit, input logic [DW-1:0] d,
                          input int n);
    fw[0] = cmd;
    fe[0] = {hit, 16'h0};
    for (int i = 1; i < n; i++) begin
      fw[i] = (i <= WORDS) ? d[(i-1)*16 +: 16] : 16'h0;
      fe[i] = {hit, 16'h0};
    end
  endtask

  localparam logic [DW-1:0] D1 = {16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
  localparam logic [DW-1:0] DA = {16'h00A5, 16'h00A4, 16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
  localparam logic [DW-1:0] DB = {16'h0, 16'h0, 16'h00B3, 16'h00B2, 16'h00B1, 16'h00B0};
  localparam logic [DW-1:0] DC = {16'hC5C5, 16'hC4C4, 16'hC3C3, 16'hC2C2, 16'hC1C1, 16'hC0C0};
  localparam logic [DW-1:0] DD = {16'hD5D5, 16'hD4D4, 16'hD3D3, 16'hD2D2, 16'hD1D1, 16'hD0D0};
  localparam logic [DW-1:0] DE = {16'hE5E5, 16'hE4E4, 16'hE3E3, 16'hE2E2, 16'hE1E1, 16'hE0E0};
  localparam logic [DW-1:0] DF = {16'hF5F5, 16'hF4F4, 16'hF3F3, 16'hF2F2, 16'hF1F1, 16'hF0F0};
  localparam logic [DW-1:0] D7 = {16'h7006, 16'h7005, 16'h7004, 16'h7003, 16'h7002, 16'h7001};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.io_din = '0;
    bus.io_strobe = 1'b0;
    bus.io_enable = 1'b0;
    inj_ch = 0;
    inj_dat = '0;
    idle(3);
    chk("rst io_dout", 256'(bus.io_dout), 256'h0);
    chk("rst dout_en", 256'(bus.dout_en), 256'h0);
    chk("rst out_data", 256'(out_data), 256'h0);
    chk("rst out_stb", 256'(out_stb), 256'h0);
    chk("rst pending", 256'(pending), 256'h0);
    rst_n = 1'b1;
    idle(2);

    // GET of channel 1 after one capture
    pulse_in(1, D1);
    chk("pending after in_stb1", 256'(pending), 256'h2);
    load_get(16'h0036, 16'h8001, D1, 7);
    frame(7, -1);
    chk("pending after get36", 256'(pending), 256'h0);
    chk("idle io_dout", 256'(bus.io_dout), 256'h0);
    chk("idle dout_en", 256'(bus.dout_en), 256'h0);

    // Full SET then short SET on channel 0
    load_set(16'h0035, 1'b1, DA, 7);
    oq.push_back('{ch: 0, dat: DA});
    frame(7, -1);
    chk("out_data ch0 after set", 256'(out_data[DW-1:0]), 256'(DA));
    load_set(16'h0035, 1'b1, DB, 5);
    frame(5, -1);
    chk("out_data ch0 after short set", 256'(out_data[DW-1:0]), 256'(DA));

    // Two captures without read: overflow and seq 2
    pulse_in(0, DC);
    pulse_in(0, DD);
    chk("pending after 2x in_stb0", 256'(pending), 256'h1);
    load_get(16'h0034, 16'hC002, DD, 7);
    frame(7, -1);
    chk("pending after get34", 256'(pending), 256'h0);
    load_get(16'h0034, 16'h0002, DD, 1);
    frame(1, -1);

    // Capture during a GET of the same channel is staged
    inj_ch = 0;
    inj_dat = DE;
    load_get(16'h0034, 16'h0002, DD, 7);
    frame(7, 3);
    chk("pending after staged get", 256'(pending), 256'h1);
    load_get(16'h0034, 16'h8003, DE, 7);
    frame(7, -1);
    chk("pending after get staged msg", 256'(pending), 256'h0);

    // Unknown command
    load_set(16'h0040, 1'b0, DF, 4);
    frame(4, -1);

    // 255 more captures on channel 1: seq 1 -> 0
    for (int i = 0; i < 255; i++) pulse_in(1, DF);
    load_get(16'h0036, 16'hC000, DF, 1);
    frame(1, -1);

    // Reset in the middle of a SET on channel 1
    @(negedge clk);
    bus.io_enable = 1'b1;
    send_word(16'h0037, {1'b1, 16'h0});
    send_word(16'h7001, {1'b1, 16'h0});
    send_word(16'h7002, {1'b1, 16'h0});
    send_word(16'h7003, {1'b1, 16'h0});
    idle(1);
    rst_n = 1'b0;
    bus.io_enable = 1'b0;
    idle(2);
    chk("midrst pending", 256'(pending), 256'h0);
    chk("midrst out_data", 256'(out_data), 256'h0);
    chk("midrst out_stb", 256'(out_stb), 256'h0);
    chk("midrst io_dout", 256'(bus.io_dout), 256'h0);
    chk("midrst dout_en", 256'(bus.dout_en), 256'h0);
    rst_n = 1'b1;
    idle(3);
    chk("post-rst out_data", 256'(out_data), 256'h0);
    load_set(16'h0037, 1'b1, D7, 7);
    oq.push_back('{ch: 1, dat: D7});
    frame(7, -1);
    chk("out_data ch1 after set", 256'(out_data[2*DW-1:DW]), 256'(D7));
    chk("out_data ch0 untouched", 256'(out_data[DW-1:0]), 256'h0);

    idle(4);
    chk("resp queue drained", 256'(rq.size()), 256'h0);
    chk("out_stb queue drained", 256'(oq.size()), 256'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hps_ext_mbox.md
# hps_ext_mbox

Parametrised multi-channel mailbox bridging the HPS extension bus (EXT_BUS) to core-side message channels. It generalises the single fixed CD GET/SET pair to NCH channels of WORDS 16-bit words each, with explicit pending/overflow status, valid strobes, and safe capture while the HPS is mid-read. It sits at top level between the HPS IO block and subsystem controllers (CD, cartridge, link cable).

## Interface
Parameters:
- NCH, 2: number of channels (1..8).
- WORDS, 6: payload words per message (1..63).
- CMD_BASE, 'h34: command code of channel 0 GET. Channel c: GET = CMD_BASE+2c, SET = CMD_BASE+2c+1.

Ports:
- clk_sys  in  1  system clock; one clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- EXT_BUS  inout  36  [15:0] io_dout (driven), [31:16] io_din, [32] dout_en (driven), [33] io_strobe, [34] io_enable.
- in_data  in  NCH*WORDS*16  core-to-HPS payload, channel c at [(c*WORDS+w)*16 +: 16].
- in_stb  in  NCH  one-cycle strobe per channel: capture in_data slice.
- out_data  out  NCH*WORDS*16  HPS-to-core payload, same packing.
- out_stb  out  NCH  one-cycle pulse when channel's out_data updates.
- pending  out  NCH  channel holds an unread core message.

## Operation
- Frame = io_enable high; word index idx (10-bit, saturates at 1023) cleared while io_enable low, +1 per io_strobe.
- idx 0: latch cmd = io_din. dout_en <= 1 iff cmd in [CMD_BASE, CMD_BASE+2*NCH-1]; stays until io_enable low. Decoded channel ch = (cmd-CMD_BASE)>>1, dir = cmd[0] relative to base parity.
- GET, idx 0 response: status word {pending[ch], overflow[ch], 6'b0, seq[ch][7:0]}.
- GET, idx 1..WORDS: io_dout <= buffer[ch] word idx-1; beyond WORDS: 0.
- GET completion: on io_enable fall with idx >= WORDS+1 -> pending[ch] and overflow[ch] cleared. Short GET: no state change.
- SET, idx 1..WORDS: io_din into shadow[ch] word idx-1; extra words ignored.
- SET completion: on io_enable fall with idx >= WORDS+1 -> out_data[ch] <= shadow[ch], out_stb[ch] pulses. Short SET discarded, no pulse.
- in_stb[c] normal: buffer[c] <= slice, pending[c] <= 1, seq[c] += 1 (wraps 255->0). If pending[c] already 1: overflow[c] <= 1 (sticky).
- in_stb[c] while a GET of channel c is in frame: slice goes to stage[c], stage_valid[c] set; buffer untouched. At frame end, completion clear applied first, then stage moves to buffer, pending set, seq incremented (overflow rule evaluated after clear). Second in_stb during same frame overwrites stage and sets overflow.
- Unknown command: dout_en 0, io_dout 0, no state change.

## Timing
- io_dout, dout_en registered: valid cycle after io_strobe; io_dout returns 0 on any non-response strobe and while io_enable low.
- io_enable fall detected via one-cycle-delayed copy; completion actions and out_stb fire the cycle after the fall is sampled; out_stb exactly one cycle.
- in_stb capture: pending visible next cycle.
- Reset: io_dout 0, dout_en 0, out_data 0, out_stb 0, pending 0, overflow 0, seq 0, stage_valid 0, idx 0, cmd 0. Reset mid-frame aborts; next frame must restart at idx 0.
- Simultaneous in_stb on several channels: all captured same cycle.

## Structure
- Package hps_ext_pkg: EXT_BUS bit positions, default CMD_BASE, status-word bit positions.
- Sub-module hps_ext_mbox_chan (one per channel via generate): buffer, stage, shadow, pending/overflow/seq, completion logic. Top holds bus decode, idx, cmd, read mux.

## Test plan
- NCH=2, WORDS=6: in_stb[1] with words 1..6 = 'h1111..'h6666, GET 'h36 of 7 words -> status 'h8001 then 'h1111..'h6666; pending[1] 0 after io_enable fall.
- SET 'h35 with 6 words 'hA0..'hA5 -> out_data ch0 = those words, out_stb[0] single pulse; SET with 4 words -> no pulse, out_data unchanged.
- Two in_stb[0] without GET -> status 'hC002; after full GET, status 'h0002.
- in_stb[0] during GET 'h34 frame -> GET returns old buffer; after frame, pending[0]=1, seq incremented, overflow 0.
- Command 'h40 -> dout_en 0, io_dout 0 all words; 256 in_stb -> seq wraps to 0.
- Assert rst_n low mid-SET -> no out_stb, all outputs 0; next full SET works.
